// File: rtl/ppu_sprite_pkg.sv
// ppu_sprite_pkg
// Shared types and helpers for the per-scanline sprite pixel engine:
//   - state_e : line-unit FSM states (IDLE / LOAD / RUN)
//   - slot_t  : contents of one sprite slot (counters, bit-planes, flags)
//   - SPRITE_W: sprite width in pixels
//   - bit_rev : mirrors a pattern byte so horizontally flipped sprites
//               can still be shifted out MSB-first
package ppu_sprite_pkg;

  localparam int SPRITE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]          x_cnt;
    logic [3:0]          remain;
    logic [SPRITE_W-1:0] pat1;
    logic [SPRITE_W-1:0] pat0;
    logic [1:0]          attr;
    logic                behind;
    logic                zero;
    logic                active;
  } slot_t;

  function automatic logic [SPRITE_W-1:0] bit_rev(input logic [SPRITE_W-1:0] v);
    logic [SPRITE_W-1:0] r;
    r = {SPRITE_W{1'b0}};
    for (int i = 0; i < SPRITE_W; i++) begin
      r[i] = v[SPRITE_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_line_unit_slot.sv
// sprite_slot
// One sprite slot: X down-counter, remaining-pixel counter and the two
// pattern shift registers. The slot waits X pixels, then presents the MSBs
// of its bit-planes for SPRITE_W pixels.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_clear            clears the slot (start of a new line)
//   i_load             write this slot from the i_* load fields
//   i_step             one screen pixel advance
//   i_x, i_pat1, i_pat0, i_attr, i_behind, i_zero   load fields (already flipped)
//   o_pattern          pattern currently presented (0 = transparent)
//   o_attr, o_behind, o_zero   slot flags
module sprite_slot
  import ppu_sprite_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_load,
  input  logic                i_step,
  input  logic [7:0]          i_x,
  input  logic [SPRITE_W-1:0] i_pat1,
  input  logic [SPRITE_W-1:0] i_pat0,
  input  logic [1:0]          i_attr,
  input  logic                i_behind,
  input  logic                i_zero,
  output logic [1:0]          o_pattern,
  output logic [1:0]          o_attr,
  output logic                o_behind,
  output logic                o_zero
);

  slot_t r_slot;
  logic  w_showing;

  // The slot is on screen once its X counter is exhausted and pixels remain.
  assign w_showing = r_slot.active && (r_slot.x_cnt == 8'd0) && (r_slot.remain != 4'd0);

  // Slot load, clear and per-pixel counting/shifting.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_slot <= {$bits(slot_t){1'b0}};
    end else if (i_load) begin
      r_slot.x_cnt  <= i_x;
      r_slot.remain <= 4'(SPRITE_W);
      r_slot.pat1   <= i_pat1;
      r_slot.pat0   <= i_pat0;
      r_slot.attr   <= i_attr;
      r_slot.behind <= i_behind;
      r_slot.zero   <= i_zero;
      r_slot.active <= 1'b1;
    end else if (i_step && r_slot.active) begin
      if (r_slot.x_cnt != 8'd0) begin
        r_slot.x_cnt <= r_slot.x_cnt - 8'd1;
      end else if (r_slot.remain != 4'd0) begin
        r_slot.pat1   <= {r_slot.pat1[SPRITE_W-2:0], 1'b0};
        r_slot.pat0   <= {r_slot.pat0[SPRITE_W-2:0], 1'b0};
        r_slot.remain <= r_slot.remain - 4'd1;
      end
    end
  end

  assign o_pattern = w_showing ? {r_slot.pat1[SPRITE_W-1], r_slot.pat0[SPRITE_W-1]} : 2'b00;
  assign o_attr    = r_slot.attr;
  assign o_behind  = r_slot.behind;
  assign o_zero    = r_slot.zero;

endmodule

// File: rtl/sprite_line_unit.sv
// sprite_line_unit
// Per-scanline sprite pixel engine. During horizontal blank it accepts up
// to NUM_SLOTS sprite entries; during the visible line it emits one
// prioritised sprite pixel per i_pixel_en with one cycle of latency.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_line_start            clear all slots, enter LOAD (wins over everything)
//   i_load_valid / o_load_ready / i_load_*   sprite load handshake and fields
//   i_run_start             start the visible line (x = 0)
//   i_pixel_en              advance one screen pixel
//   o_pix_valid, o_pix_*    registered winning sprite pixel
//   o_overflow              sticky: too many sprites offered this line
//   o_busy                  line is running
module sprite_line_unit
  import ppu_sprite_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int LINE_PIXELS = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_line_start,
  input  logic       i_load_valid,
  output logic       o_load_ready,
  input  logic [7:0] i_load_x,
  input  logic [7:0] i_load_pat1,
  input  logic [7:0] i_load_pat0,
  input  logic [1:0] i_load_attr,
  input  logic       i_load_hflip,
  input  logic       i_load_behind,
  input  logic       i_load_zero,
  input  logic       i_run_start,
  input  logic       i_pixel_en,
  output logic       o_pix_valid,
  output logic [1:0] o_pix_pattern,
  output logic [1:0] o_pix_attr,
  output logic       o_pix_behind,
  output logic       o_pix_zero,
  output logic       o_overflow,
  output logic       o_busy
);

  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam int PW = $clog2(LINE_PIXELS + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_px_cnt;
  logic             r_overflow;
  logic             r_pix_valid;
  logic [1:0]       r_pix_pattern;
  logic [1:0]       r_pix_attr;
  logic             r_pix_behind;
  logic             r_pix_zero;

  logic             w_in_load;
  logic             w_load_ready;
  logic             w_load_acc;
  logic             w_px_adv;
  logic             w_last_px;
  logic [SPRITE_W-1:0] w_pat1_in;
  logic [SPRITE_W-1:0] w_pat0_in;

  logic [1:0]       w_slot_pat    [NUM_SLOTS];
  logic [1:0]       w_slot_attr   [NUM_SLOTS];
  logic             w_slot_behind [NUM_SLOTS];
  logic             w_slot_zero   [NUM_SLOTS];

  logic [1:0]       w_win_pat;
  logic [1:0]       w_win_attr;
  logic             w_win_behind;
  logic             w_win_zero;

  assign w_in_load    = (r_state == ST_LOAD);
  assign w_load_ready = w_in_load && (r_count < CW'(NUM_SLOTS));
  // line_start clears everything in the same cycle, so it masks loads and pixels.
  assign w_load_acc   = i_load_valid && w_load_ready && !i_line_start;
  assign w_px_adv     = (r_state == ST_RUN) && i_pixel_en && !i_line_start;
  assign w_last_px    = w_px_adv && (r_px_cnt == PW'(LINE_PIXELS - 1));

  // Flip at load time so every slot always shifts MSB-first.
  assign w_pat1_in = i_load_hflip ? bit_rev(i_load_pat1) : i_load_pat1;
  assign w_pat0_in = i_load_hflip ? bit_rev(i_load_pat0) : i_load_pat0;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (i_line_start) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_LOAD: w_state_nxt = i_run_start ? ST_RUN : ST_LOAD;
        ST_RUN:  w_state_nxt = w_last_px ? ST_IDLE : ST_RUN;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Load counter, pixel counter and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_line_start) begin
      r_count    <= {CW{1'b0}};
      r_px_cnt   <= {PW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_load_acc) begin
        r_count <= r_count + CW'(1);
      end
      if (w_in_load && i_load_valid && (r_count == CW'(NUM_SLOTS))) begin
        r_overflow <= 1'b1;
      end
      if (w_in_load && i_run_start) begin
        r_px_cnt <= {PW{1'b0}};
      end else if (w_px_adv) begin
        r_px_cnt <= r_px_cnt + PW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sprite_slot u_slot (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (i_line_start),
      .i_load    (w_load_acc && (r_count == CW'(g))),
      .i_step    (w_px_adv),
      .i_x       (i_load_x),
      .i_pat1    (w_pat1_in),
      .i_pat0    (w_pat0_in),
      .i_attr    (i_load_attr),
      .i_behind  (i_load_behind),
      .i_zero    (i_load_zero),
      .o_pattern (w_slot_pat[g]),
      .o_attr    (w_slot_attr[g]),
      .o_behind  (w_slot_behind[g]),
      .o_zero    (w_slot_zero[g])
    );
  end

  // Priority encoder: scan from the highest slot down so the lowest
  // opaque slot is the last to overwrite the winner.
  always_comb begin
    w_win_pat    = 2'b00;
    w_win_attr   = 2'b00;
    w_win_behind = 1'b0;
    w_win_zero   = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_win_attr   = (w_slot_pat[i] != 2'b00) ? w_slot_attr[i]   : w_win_attr;
      w_win_behind = (w_slot_pat[i] != 2'b00) ? w_slot_behind[i] : w_win_behind;
      w_win_zero   = (w_slot_pat[i] != 2'b00) ? w_slot_zero[i]   : w_win_zero;
      w_win_pat    = (w_slot_pat[i] != 2'b00) ? w_slot_pat[i]    : w_win_pat;
    end
  end

  // Output pixel register; data holds while no pixel is advanced.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_valid   <= 1'b0;
      r_pix_pattern <= 2'b00;
      r_pix_attr    <= 2'b00;
      r_pix_behind  <= 1'b0;
      r_pix_zero    <= 1'b0;
    end else if (w_px_adv) begin
      r_pix_valid   <= 1'b1;
      r_pix_pattern <= w_win_pat;
      r_pix_attr    <= w_win_attr;
      r_pix_behind  <= w_win_behind;
      r_pix_zero    <= w_win_zero;
    end else begin
      r_pix_valid   <= 1'b0;
    end
  end

  assign o_load_ready  = w_load_ready;
  assign o_pix_valid   = r_pix_valid;
  assign o_pix_pattern = r_pix_pattern;
  assign o_pix_attr    = r_pix_attr;
  assign o_pix_behind  = r_pix_behind;
  assign o_pix_zero    = r_pix_zero;
  assign o_overflow    = r_overflow;
  assign o_busy        = (r_state == ST_RUN);

endmodule

// File: tb/tb_sprite_line_unit.sv
// tb_sprite_line_unit
// Directed bench for sprite_line_unit. Expected pixels come from a
// behavioural model of the loaded sprites and are queued when pixel_en
// is driven, then popped when the DUT produces its registered pixel.
module tb_sprite_line_unit;

  localparam int NS = 8;
  localparam int LP = 256;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_line_start = 1'b0;
  logic       i_load_valid = 1'b0;
  logic       o_load_ready;
  logic [7:0] i_load_x = 8'd0;
  logic [7:0] i_load_pat1 = 8'd0;
  logic [7:0] i_load_pat0 = 8'd0;
  logic [1:0] i_load_attr = 2'd0;
  logic       i_load_hflip = 1'b0;
  logic       i_load_behind = 1'b0;
  logic       i_load_zero = 1'b0;
  logic       i_run_start = 1'b0;
  logic       i_pixel_en = 1'b0;
  logic       o_pix_valid;
  logic [1:0] o_pix_pattern;
  logic [1:0] o_pix_attr;
  logic       o_pix_behind;
  logic       o_pix_zero;
  logic       o_overflow;
  logic       o_busy;

  sprite_line_unit #(.NUM_SLOTS(NS), .LINE_PIXELS(LP)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_line_start (i_line_start),
    .i_load_valid (i_load_valid),
    .o_load_ready (o_load_ready),
    .i_load_x     (i_load_x),
    .i_load_pat1  (i_load_pat1),
    .i_load_pat0  (i_load_pat0),
    .i_load_attr  (i_load_attr),
    .i_load_hflip (i_load_hflip),
    .i_load_behind(i_load_behind),
    .i_load_zero  (i_load_zero),
    .i_run_start  (i_run_start),
    .i_pixel_en   (i_pixel_en),
    .o_pix_valid  (o_pix_valid),
    .o_pix_pattern(o_pix_pattern),
    .o_pix_attr   (o_pix_attr),
    .o_pix_behind (o_pix_behind),
    .o_pix_zero   (o_pix_zero),
    .o_overflow   (o_overflow),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [5:0] q_exp [$];
  int         q_x   [$];

  // Reference model of the sprites accepted on the current line.
  logic [7:0] m_x    [NS];
  logic [7:0] m_p1   [NS];
  logic [7:0] m_p0   [NS];
  logic [1:0] m_attr [NS];
  logic       m_flip [NS];
  logic       m_beh  [NS];
  logic       m_zero [NS];
  int         m_n   = 0;
  logic       m_ovf = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {pattern, attr, behind, zero} expected at screen x.
  function automatic logic [5:0] model_pix(input int x);
    int d;
    int b;
    logic [1:0] p;
    for (int s = 0; s < m_n; s++) begin
      d = x - int'(m_x[s]);
      if (d >= 0 && d < 8) begin
        b = m_flip[s] ? d : 7 - d;
        p = {m_p1[s][b], m_p0[s][b]};
        if (p != 2'b00) return {p, m_attr[s], m_beh[s], m_zero[s]};
      end
    end
    return 6'd0;
  endfunction

  task automatic tick();
    logic       exp_v;
    logic [5:0] e;
    int         x;
    @(posedge i_clk);
    #1;
    exp_v = (q_exp.size() != 0);
    check("pix_valid", {15'd0, o_pix_valid}, {15'd0, exp_v});
    if (exp_v) begin
      e = q_exp.pop_front();
      x = q_x.pop_front();
      check($sformatf("pix x=%0d", x),
            {10'd0, o_pix_pattern, o_pix_attr, o_pix_behind, o_pix_zero}, {10'd0, e});
    end
  endtask

  task automatic do_line_start();
    i_line_start = 1'b1;
    tick();
    i_line_start = 1'b0;
    m_n   = 0;
    m_ovf = 1'b0;
    check("ls load_ready", {15'd0, o_load_ready}, 16'd1);
    check("ls overflow",   {15'd0, o_overflow},   16'd0);
    check("ls busy",       {15'd0, o_busy},       16'd0);
  endtask

  task automatic load(input logic [7:0] x, input logic [7:0] p1, input logic [7:0] p0,
                      input logic [1:0] attr, input logic flip, input logic beh,
                      input logic zero);
    logic acc;
    acc = (m_n < NS);
    i_load_valid  = 1'b1;
    i_load_x      = x;
    i_load_pat1   = p1;
    i_load_pat0   = p0;
    i_load_attr   = attr;
    i_load_hflip  = flip;
    i_load_behind = beh;
    i_load_zero   = zero;
    check("load_ready", {15'd0, o_load_ready}, {15'd0, acc});
    tick();
    i_load_valid = 1'b0;
    if (acc) begin
      m_x[m_n] = x; m_p1[m_n] = p1; m_p0[m_n] = p0; m_attr[m_n] = attr;
      m_flip[m_n] = flip; m_beh[m_n] = beh; m_zero[m_n] = zero;
      m_n++;
    end else begin
      m_ovf = 1'b1;
    end
    check("overflow", {15'd0, o_overflow}, {15'd0, m_ovf});
  endtask

  // Runs a full line; gap > 0 inserts an idle cycle after every gap pixels.
  task automatic run_line(input int gap);
    i_run_start = 1'b1;
    tick();
    i_run_start = 1'b0;
    check("busy rise", {15'd0, o_busy}, 16'd1);
    for (int x = 0; x < LP; x++) begin
      i_pixel_en = 1'b1;
      q_exp.push_back(model_pix(x));
      q_x.push_back(x);
      tick();
      i_pixel_en = 1'b0;
      if (x == LP - 2) check("busy before last", {15'd0, o_busy}, 16'd1);
      if (x == LP - 1) check("busy fall", {15'd0, o_busy}, 16'd0);
      if (gap > 0 && (x % gap) == gap - 1) tick();
    end
    // pixel_en after the line ends must not produce a pixel
    i_pixel_en = 1'b1;
    tick();
    i_pixel_en = 1'b0;
  endtask

  initial begin
    logic [7:0] p1;
    logic [7:0] p0;

    // Reset state
    tick();
    tick();
    i_rst = 1'b0;
    check("rst load_ready", {15'd0, o_load_ready}, 16'd0);
    check("rst pix", {10'd0, o_pix_pattern, o_pix_attr, o_pix_behind, o_pix_zero}, 16'd0);
    check("rst overflow", {15'd0, o_overflow}, 16'd0);
    check("rst busy", {15'd0, o_busy}, 16'd0);

    // Single sprite, no flip
    do_line_start();
    load(8'd10, 8'h80, 8'h01, 2'd0, 1'b0, 1'b0, 1'b0);
    run_line(0);

    // Same sprite flipped, gapped pixel_en
    do_line_start();
    load(8'd10, 8'h80, 8'h01, 2'd2, 1'b1, 1'b1, 1'b0);
    run_line(3);

    // Two overlapping slots: slot 0 wins where it is opaque
    do_line_start();
    load(8'd20, 8'h00, 8'hFF, 2'd1, 1'b0, 1'b0, 1'b0);
    load(8'd16, 8'hFF, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0);
    run_line(0);

    // Nine offers into eight slots; overlapping sprites exercise priority
    do_line_start();
    for (int i = 0; i < 9; i++) begin
      p1 = 8'(i * 37 + 11);
      p0 = 8'(8'hC3 ^ 8'(i * 29));
      load(8'(40 + 3 * i), p1, p0, 2'(i), i[0], i[1], (i == 0));
    end
    check("ready after full", {15'd0, o_load_ready}, 16'd0);
    run_line(0);
    check("overflow sticky", {15'd0, o_overflow}, 16'd1);
    do_line_start();

    // Right-edge clip with sprite 0
    load(8'd252, 8'h00, 8'hFF, 2'd2, 1'b0, 1'b1, 1'b1);
    run_line(0);

    // Reset in the middle of a line
    do_line_start();
    load(8'd96, 8'h00, 8'hFF, 2'd2, 1'b0, 1'b0, 1'b1);
    i_run_start = 1'b1;
    tick();
    i_run_start = 1'b0;
    for (int x = 0; x < 100; x++) begin
      i_pixel_en = 1'b1;
      q_exp.push_back(model_pix(x));
      q_x.push_back(x);
      tick();
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_pixel_en = 1'b0;
    m_n = 0;
    check("midrst pix", {10'd0, o_pix_pattern, o_pix_attr, o_pix_behind, o_pix_zero}, 16'd0);
    check("midrst busy", {15'd0, o_busy}, 16'd0);
    check("midrst load_ready", {15'd0, o_load_ready}, 16'd0);
    check("midrst overflow", {15'd0, o_overflow}, 16'd0);

    // IDLE: pixel_en and load_valid are ignored
    i_pixel_en   = 1'b1;
    i_load_valid = 1'b1;
    tick();
    i_pixel_en   = 1'b0;
    i_load_valid = 1'b0;
    check("idle overflow", {15'd0, o_overflow}, 16'd0);
    check("idle busy", {15'd0, o_busy}, 16'd0);

    // line_start beats run_start; then an empty line is transparent
    i_line_start = 1'b1;
    i_run_start  = 1'b1;
    tick();
    i_line_start = 1'b0;
    i_run_start  = 1'b0;
    check("ls+rs load_ready", {15'd0, o_load_ready}, 16'd1);
    check("ls+rs busy", {15'd0, o_busy}, 16'd0);
    m_n = 0;
    run_line(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_line_unit.md
# sprite_line_unit

Per-scanline sprite pixel engine with `NUM_SLOTS` sprite slots, front-to-back priority, sprite-0 tracking and overflow detection. It takes over from the single-sprite visibility check. During horizontal blank, an upstream evaluator loads it with the row-selected pattern bytes of up to `NUM_SLOTS` sprites. During the visible line it emits one sprite pixel per `pixel_en`, and that pixel feeds the palette address mux.

## Interface
- `NUM_SLOTS`, default 8: sprites per scanline; minimum 1.
- `LINE_PIXELS`, default 256: visible pixels per line. RUN ends after this many pixels.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `line_start`  input  1  pulse that clears all slots and enters LOAD.
- `load_valid`  input  1  load entry offered.
- `load_ready`  output  1  slot available (LOAD state and `count < NUM_SLOTS`).
- `load_x`  input  8  sprite X.
- `load_pat1`, `load_pat0`  input  8 each  pattern bit-planes for the current row; bit 7 is the leftmost pixel.
- `load_attr`  input  2  palette attribute.
- `load_hflip`  input  1  horizontal flip.
- `load_behind`  input  1  priority-behind-background flag.
- `load_zero`  input  1  entry is OAM sprite 0.
- `run_start`  input  1  pulse that starts the visible line; x = 0.
- `pixel_en`  input  1  advance one screen pixel.
- `pix_valid`  output  1  registered; pixel outputs correspond to the previous `pixel_en`.
- `pix_pattern`  output  2  winning pattern bits; 0 = transparent.
- `pix_attr`  output  2  attribute of the winning slot.
- `pix_behind`  output  1  priority flag of the winning slot.
- `pix_zero`  output  1  winning slot is sprite 0.
- `overflow`  output  1  sticky until the next `line_start`.
- `busy`  output  1  state is RUN.

## Operation
- States: IDLE, LOAD, RUN.
  - IDLE → LOAD on `line_start`.
  - LOAD → RUN on `run_start`.
  - RUN → IDLE after `LINE_PIXELS` accepted `pixel_en`.
  - `line_start` from any state → LOAD. It clears `count`, all slot-active bits and `overflow`.
- Loading:
  - A load is accepted when `load_valid && load_ready`. It writes the slot at index `count`, then `count++`.
  - If `load_hflip` = 1, the pattern bytes are bit-reversed at load, so shifting is always MSB-first.
  - `load_valid` while in LOAD with `count == NUM_SLOTS` sets `overflow`. The entry is discarded.
  - `load_valid` outside LOAD is ignored and does not set `overflow`.
- Run:
  - Each slot holds an 8-bit X down-counter and a 4-bit remaining-pixel counter initialised to 8.
  - On each `pixel_en`, for an active slot:
    - If the X counter is nonzero, it decrements.
    - Otherwise, if remaining > 0, the slot presents `{pat1[7], pat0[7]}`, then both planes shift left and remaining decrements.
  - A slot is therefore visible exactly for screen x in [X, X+7]. Pixels beyond `LINE_PIXELS − 1` are never shown (right-edge clip), and there is no wrap.
- Priority: the lowest-index slot presenting a nonzero pattern wins. If no slot presents a nonzero pattern, all `pix_*` outputs are 0.
- `pixel_en` outside RUN: `pix_valid` = 0 and no state changes.
- `run_start` with `count` = 0: the full line is transparent.
- `run_start` during RUN is ignored.
- `line_start` and `run_start` in the same cycle: `line_start` wins.
- `rst`:
  - Goes to IDLE and clears `count` and all slots.
  - Reset value of every output: `load_ready`, `pix_valid`, `pix_pattern`, `pix_attr`, `pix_behind`, `pix_zero`, `overflow` and `busy` all 0.
  - `rst` mid-RUN takes effect on the next edge.

## Timing
- Load throughput: 1 entry per cycle. `load_ready` is combinational from state and `count`, and falls the cycle after the `NUM_SLOTS`-th accept.
- Pixel latency: 1 cycle. The pixel for the k-th `pixel_en` of the line (x = k) appears with `pix_valid` = 1 on the following cycle.
- `pixel_en` may be held continuously or gapped. Outputs hold their last value while `pix_valid` = 0.
- `overflow` rises 1 cycle after the offending `load_valid`.
- `busy` rises 1 cycle after `run_start`. It falls on the cycle after the `LINE_PIXELS`-th `pixel_en`, coincident with the last `pix_valid`.

## Structure
- Package `ppu_sprite_pkg` holds:
  - the state enum (IDLE/LOAD/RUN);
  - the slot record type (x counter, remaining, pat1, pat0, attr, behind, zero, active);
  - the constant `SPRITE_W` = 8.
- Sub-module `sprite_slot`, instantiated `NUM_SLOTS` times, holds one slot's counters and shifters. It outputs its present pattern plus attribute flags.
- The top level holds the FSM, the load counter, the overflow flag and the priority encoder.

## Test plan
- Load 1 sprite, X = 10, pat1 = 0x80, pat0 = 0x01, no flip; run 256 px → pattern 2 at x = 10, 1 at x = 17, 0 elsewhere.
- Same sprite with hflip = 1 → pattern 1 at x = 10, 2 at x = 17.
- Slot 0 (X = 20, pat0 = 0xFF, attr = 1) and slot 1 (X = 16, pat1 = 0xFF, attr = 3) → x = 16..19 pattern 2 / attr 3; x = 20..27 pattern 1 / attr 1.
- Offer 9 loads with NUM_SLOTS = 8 → `load_ready` = 0 after the 8th accept; `overflow` = 1 one cycle after the 9th; cleared by the next `line_start`.
- X = 252, pat0 = 0xFF, `load_zero` = 1 → `pix_zero` = 1 and pattern 1 at x = 252..255 only; `busy` falls after x = 255.
- Assert `rst` at x = 100 mid-RUN → next cycle all outputs 0 and state IDLE; `line_start` together with `run_start` → LOAD.
